// File: rtl/charbuf_cmd_ctrl_if.sv
// Byte-stream and buffer-write bundle for charbuf_cmd_ctrl.
//   rx_data/rx_valid/rx_ready : UART byte stream, valid/ready handshake
//   hold                      : refresh sequencer freeze, no buffer write commits while high
//   rnd_color                 : LFSR color sampled when a printable byte is accepted
//   wr_en/wr_addr/wr_char/wr_color : single-entry write to textbuf/colorbuf
//   cursor, busy              : status
// The slave modport is the controller's view; master is the surrounding system.
interface charbuf_cmd_ctrl_if #(
  parameter int ADDR_W = 3
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              hold;
  logic [3:0]        rnd_color;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_char;
  logic [3:0]        wr_color;
  logic [ADDR_W-1:0] cursor;
  logic              busy;

  modport slave (
    input  rx_data, rx_valid, hold, rnd_color,
    output rx_ready, wr_en, wr_addr, wr_char, wr_color, cursor, busy
  );

  modport master (
    output rx_data, rx_valid, hold, rnd_color,
    input  rx_ready, wr_en, wr_addr, wr_char, wr_color, cursor, busy
  );
endinterface

// File: rtl/charbuf_cmd_ctrl.sv
// Command controller between the UART receiver and the character-matrix
// text/color buffers. Decodes printable bytes and control codes into
// single-cell (char, color) writes at the cursor.
// Ports:
//   clk20 : 20 MHz system clock
//   reset : asynchronous active-high reset
//   bus   : charbuf_cmd_ctrl_if.slave (byte stream in, buffer write out, status)
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for a byte; printable/control decode
// ESC_COLOR | next byte's low nibble becomes the current color
// ESC_POS   | next byte sets the cursor if it addresses a valid cell
// WRITE     | one (char, color) write pending, commits when hold is low
// CLEAR     | writing blanks to every cell, one per unheld cycle
module charbuf_cmd_ctrl #(
  parameter int NUM_CHARS = 4,
  parameter int ADDR_W    = 3,
  parameter int RND_CODE  = 15
) (
  input  logic               clk20,
  input  logic               reset,
  charbuf_cmd_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ESC_COLOR,
    S_ESC_POS,
    S_WRITE,
    S_CLEAR
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_CHARS - 1);
  localparam logic [3:0]        RND      = 4'(RND_CODE);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cursor_q, cursor_d;
  logic [3:0]        cur_color_q, cur_color_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_char_q, wr_char_d;
  logic [3:0]        wr_color_q, wr_color_d;

  logic rx_ready_w;
  logic busy_w;
  logic accept;
  logic commit;

  // Handshake and strobe come straight from the state register so rx_ready
  // never depends on rx_valid, and hold gates the strobe in the same cycle.
  assign rx_ready_w = (state_q == S_IDLE) || (state_q == S_ESC_COLOR) || (state_q == S_ESC_POS);
  assign busy_w     = (state_q == S_WRITE) || (state_q == S_CLEAR);
  assign accept     = bus.rx_valid & rx_ready_w;
  assign commit     = busy_w & ~bus.hold;

  always_comb begin
    state_d     = state_q;
    cursor_d    = cursor_q;
    cur_color_d = cur_color_q;
    clr_idx_d   = clr_idx_q;
    wr_addr_d   = wr_addr_q;
    wr_char_d   = wr_char_q;
    wr_color_d  = wr_color_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.rx_data >= 8'h20 && bus.rx_data <= 8'h7E) begin
            wr_addr_d  = cursor_q;
            wr_char_d  = bus.rx_data;
            wr_color_d = (cur_color_q == RND) ? bus.rnd_color : cur_color_q;
            state_d    = S_WRITE;
          end else begin
            case (bus.rx_data)
              8'h0D: cursor_d = '0;
              8'h08: if (cursor_q != '0) cursor_d = cursor_q - ADDR_W'(1);
              8'h1B: state_d = S_ESC_COLOR;
              8'h10: state_d = S_ESC_POS;
              8'h0C: begin
                // The first blank is staged here so CLEAR commits from its first cycle.
                clr_idx_d  = '0;
                wr_addr_d  = '0;
                wr_char_d  = 8'h20;
                wr_color_d = 4'h0;
                state_d    = S_CLEAR;
              end
              default: ;
            endcase
          end
        end
      end

      S_ESC_COLOR: begin
        if (accept) begin
          cur_color_d = bus.rx_data[3:0];
          state_d     = S_IDLE;
        end
      end

      S_ESC_POS: begin
        if (accept) begin
          if ({24'd0, bus.rx_data} < 32'(NUM_CHARS)) cursor_d = bus.rx_data[ADDR_W-1:0];
          state_d = S_IDLE;
        end
      end

      S_WRITE: begin
        if (commit) begin
          cursor_d = (cursor_q == LAST_IDX) ? '0 : cursor_q + ADDR_W'(1);
          state_d  = S_IDLE;
        end
      end

      S_CLEAR: begin
        if (commit) begin
          if (clr_idx_q == LAST_IDX) begin
            cursor_d = '0;
            state_d  = S_IDLE;
          end else begin
            clr_idx_d = clr_idx_q + ADDR_W'(1);
            wr_addr_d = clr_idx_q + ADDR_W'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk20 or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cursor_q    <= '0;
      cur_color_q <= 4'h1;
      clr_idx_q   <= '0;
      wr_addr_q   <= '0;
      wr_char_q   <= 8'h00;
      wr_color_q  <= 4'h0;
    end else begin
      state_q     <= state_d;
      cursor_q    <= cursor_d;
      cur_color_q <= cur_color_d;
      clr_idx_q   <= clr_idx_d;
      wr_addr_q   <= wr_addr_d;
      wr_char_q   <= wr_char_d;
      wr_color_q  <= wr_color_d;
    end
  end

  assign bus.rx_ready = rx_ready_w;
  assign bus.busy     = busy_w;
  assign bus.wr_en    = commit;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_char  = wr_char_q;
  assign bus.wr_color = wr_color_q;
  assign bus.cursor   = cursor_q;

endmodule

// File: tb/tb_charbuf_cmd_ctrl.sv
// Bench for charbuf_cmd_ctrl: a queue-of-pending-writes model predicts every
// output each cycle; directed sequences pin the model with literal values,
// then a randomized byte stream with random hold runs against the model.
module tb_charbuf_cmd_ctrl;
  localparam int NUM_CHARS = 4;
  localparam int ADDR_W    = 3;
  localparam int RND_CODE  = 15;

  logic clk20 = 1'b0;
  logic reset = 1'b1;

  charbuf_cmd_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  charbuf_cmd_ctrl #(
    .NUM_CHARS(NUM_CHARS),
    .ADDR_W   (ADDR_W),
    .RND_CODE (RND_CODE)
  ) dut (
    .clk20(clk20),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk20 = ~clk20;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Each pending buffer write; cur_after is the cursor once it commits (-1: unchanged).
  typedef struct {
    int addr;
    int chr;
    int col;
    int cur_after;
  } wr_t;

  wr_t mq[$];
  wr_t wlog[$];
  int  m_cursor = 0;
  int  m_color  = 1;
  int  m_mode   = 0;   // 0 plain, 1 expecting color argument, 2 expecting position argument
  bit  rand_hold = 1'b0;

  task automatic model_byte(input int b, input int rnd);
    if (m_mode == 1) begin
      m_color = b % 16;
      m_mode  = 0;
    end else if (m_mode == 2) begin
      if (b < NUM_CHARS) m_cursor = b;
      m_mode = 0;
    end else if (b >= 32 && b <= 126) begin
      mq.push_back('{m_cursor, b, (m_color == RND_CODE) ? rnd : m_color, (m_cursor + 1) % NUM_CHARS});
    end else if (b == 8'h0D) begin
      m_cursor = 0;
    end else if (b == 8'h08) begin
      if (m_cursor > 0) m_cursor = m_cursor - 1;
    end else if (b == 8'h1B) begin
      m_mode = 1;
    end else if (b == 8'h10) begin
      m_mode = 2;
    end else if (b == 8'h0C) begin
      for (int i = 0; i < NUM_CHARS; i++)
        mq.push_back('{i, 8'h20, 0, (i == NUM_CHARS - 1) ? 0 : -1});
    end
  endtask

  // Model advance: a pending write blocks input; it retires on any unheld edge.
  initial begin
    forever begin
      @(posedge clk20 or posedge reset);
      if (reset) begin
        mq.delete();
        m_cursor = 0;
        m_color  = 1;
        m_mode   = 0;
      end else if (mq.size() != 0) begin
        if (!bus.hold) begin
          if (mq[0].cur_after >= 0) m_cursor = mq[0].cur_after;
          void'(mq.pop_front());
        end
      end else if (bus.rx_valid) begin
        model_byte(int'(bus.rx_data), int'(bus.rnd_color));
      end
    end
  end

  // Compare every cycle mid-period; also log every actual commit.
  initial begin
    bit eb;
    forever begin
      @(negedge clk20);
      if (bus.wr_en === 1'b1)
        wlog.push_back('{int'(bus.wr_addr), int'(bus.wr_char), int'(bus.wr_color), 0});
      if (!reset) begin
        eb = (mq.size() != 0);
        check("rx_ready", bus.rx_ready, !eb);
        check("busy", bus.busy, eb);
        check("wr_en", bus.wr_en, eb && !bus.hold);
        check("cursor", bus.cursor, m_cursor);
        if (eb) begin
          check("wr_addr", bus.wr_addr, mq[0].addr);
          check("wr_char", bus.wr_char, mq[0].chr);
          check("wr_color", bus.wr_color, mq[0].col);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk20);
      #2;
      if (rand_hold) bus.hold = ($urandom % 4 == 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk20);
    #2;
  endtask

  task automatic send(input logic [7:0] b, input logic [3:0] rnd);
    int  n;
    bit  rdy;
    n = 0;
    bus.rx_data   = b;
    bus.rnd_color = rnd;
    bus.rx_valid  = 1'b1;
    forever begin
      @(negedge clk20);
      rdy = bus.rx_ready;
      @(posedge clk20);
      if (rdy) break;
      n++;
      if (n > 200) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    #2;
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    forever begin
      @(posedge clk20);
      #2;
      if (mq.size() == 0) break;
      n++;
      if (n > 200) begin
        check("idle_timeout", 0, 1);
        break;
      end
    end
  endtask

  initial begin
    int base;
    int r;
    logic [7:0] b;
    logic [7:0] ctl [5];
    ctl[0] = 8'h0D; ctl[1] = 8'h08; ctl[2] = 8'h1B; ctl[3] = 8'h10; ctl[4] = 8'h0C;

    bus.rx_data   = 8'h00;
    bus.rx_valid  = 1'b0;
    bus.hold      = 1'b0;
    bus.rnd_color = 4'h0;
    reset = 1'b1;
    repeat (3) @(posedge clk20);
    #2 reset = 1'b0;

    @(negedge clk20);
    check("rst_rx_ready", bus.rx_ready, 1);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_cursor", bus.cursor, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_char", bus.wr_char, 0);
    check("rst_wr_color", bus.wr_color, 0);
    @(posedge clk20);
    #2;

    // "AB"
    base = wlog.size();
    send(8'h41, 4'h0);
    send(8'h42, 4'h0);
    wait_idle();
    check("ab_count", wlog.size() - base, 2);
    check("ab0_addr", wlog[base].addr, 0);
    check("ab0_char", wlog[base].chr, 8'h41);
    check("ab0_col", wlog[base].col, 1);
    check("ab1_addr", wlog[base+1].addr, 1);
    check("ab1_char", wlog[base+1].chr, 8'h42);
    check("ab1_col", wlog[base+1].col, 1);
    check("ab_cursor", bus.cursor, 2);

    // Cursor wrap, then backspace saturation
    send(8'h0D, 4'h0);
    base = wlog.size();
    for (int i = 0; i < 5; i++) send(8'h61 + 8'(i), 4'h0);
    wait_idle();
    check("wrap_count", wlog.size() - base, 5);
    check("wrap_a0", wlog[base].addr, 0);
    check("wrap_a3", wlog[base+3].addr, 3);
    check("wrap_a4", wlog[base+4].addr, 0);
    check("wrap_cursor", bus.cursor, 1);
    send(8'h08, 4'h0);
    check("bs1_cursor", bus.cursor, 0);
    send(8'h08, 4'h0);
    check("bs2_cursor", bus.cursor, 0);

    // Color, random color, position
    send(8'h1B, 4'h0); send(8'h23, 4'h0); send(8'h58, 4'h0); wait_idle();
    check("esc_color", wlog[wlog.size()-1].col, 3);
    send(8'h1B, 4'h0); send(8'h0F, 4'h0); send(8'h59, 4'hA); wait_idle();
    check("rnd_color", wlog[wlog.size()-1].col, 4'hA);
    send(8'h10, 4'h0); send(8'h02, 4'h0); send(8'h5A, 4'h0); wait_idle();
    check("pos_addr", wlog[wlog.size()-1].addr, 2);
    check("pos_cursor", bus.cursor, 3);
    send(8'h10, 4'h0); send(8'h07, 4'h0);
    check("pos_oor_cursor", bus.cursor, 3);

    // Clear
    base = wlog.size();
    send(8'h0C, 4'h0);
    wait_idle();
    check("clr_count", wlog.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      check("clr_addr", wlog[base+i].addr, i);
      check("clr_char", wlog[base+i].chr, 8'h20);
      check("clr_col", wlog[base+i].col, 0);
    end
    check("clr_cursor", bus.cursor, 0);

    // Hold across a printable write (color is RND_CODE here)
    bus.hold = 1'b1;
    base = wlog.size();
    send(8'h51, 4'h5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk20);
      check("hold_wr_en", bus.wr_en, 0);
      check("hold_rx_ready", bus.rx_ready, 0);
      check("hold_wr_char", bus.wr_char, 8'h51);
      check("hold_wr_color", bus.wr_color, 5);
      @(posedge clk20);
      #2;
    end
    bus.hold = 1'b0;
    @(negedge clk20);
    check("hold_release_wr_en", bus.wr_en, 1);
    wait_idle();
    check("hold_count", wlog.size() - base, 1);

    // Clear with hold toggling
    base = wlog.size();
    send(8'h0C, 4'h0);
    for (int i = 0; i < 100 && mq.size() != 0; i++) begin
      bus.hold = $urandom % 2;
      @(posedge clk20);
      #2;
    end
    bus.hold = 1'b0;
    wait_idle();
    check("clr_hold_count", wlog.size() - base, 4);

    // Reset in the 2nd cycle of CLEAR
    send(8'h0C, 4'h0);
    @(posedge clk20);
    #2;
    base = wlog.size();
    reset = 1'b1;
    #1;
    check("rst_async_wr_en", bus.wr_en, 0);
    check("rst_async_busy", bus.busy, 0);
    cycles(3);
    check("rst_no_writes", wlog.size() - base, 0);
    reset = 1'b0;
    @(negedge clk20);
    check("rel_cursor", bus.cursor, 0);
    check("rel_rx_ready", bus.rx_ready, 1);
    @(posedge clk20);
    #2;
    send(8'h43, 4'h7);
    wait_idle();
    check("rel_color", wlog[wlog.size()-1].col, 1);
    check("rel_addr", wlog[wlog.size()-1].addr, 0);

    // Randomized stream with random hold
    rand_hold = 1'b1;
    for (int i = 0; i < 300; i++) begin
      r = $urandom % 10;
      if (r < 6)       b = 8'($urandom_range(32, 126));
      else if (r < 9)  b = ctl[$urandom % 5];
      else             b = 8'($urandom % 256);
      send(b, 4'($urandom % 16));
      if ($urandom % 4 == 0) cycles($urandom % 3 + 1);
    end
    rand_hold = 1'b0;
    @(posedge clk20);
    #2;
    bus.hold = 1'b0;
    wait_idle();
    cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/charbuf_cmd_ctrl.md
Name: charbuf_cmd_ctrl

Overview:
Command controller between the UART receiver and the character-matrix text/color buffers. It consumes the received byte stream through a valid/ready handshake. It decodes printable characters and a small set of control codes into single-entry writes of (char, color) at a cursor position. A hold input lets the LED refresh sequencer freeze buffer writes while it walks the buffer, so the two never collide.

Parameters:
NUM_CHARS, 4, number of character cells; must satisfy 1 <= NUM_CHARS <= 2^ADDR_W
ADDR_W, 3, width of the cell address and cursor
RND_CODE, 15, color code meaning "use rnd_color at accept time"

Ports:
clk20  input  1  system clock (20 MHz)
reset  input  1  asynchronous, active-high reset
rx_data  input  8  received byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  controller can accept a byte; a transfer occurs on a clk20 edge with rx_valid & rx_ready
hold  input  1  refresh in progress; no write may commit while high
rnd_color  input  4  random color from the LFSR shift register
wr_en  output  1  write strobe to textbuf/colorbuf; commits on the clk20 edge where it is high
wr_addr  output  ADDR_W  cell address
wr_char  output  8  character code
wr_color  output  4  color index
cursor  output  ADDR_W  current cursor position
busy  output  1  high in WRITE or CLEAR

Behaviour:
- States: IDLE, ESC_COLOR, ESC_POS, WRITE, CLEAR.
- Reset values: state IDLE, cursor 0, cur_color 1, clr_idx 0. wr_addr, wr_char and wr_color are all 0. wr_en 0, busy 0, rx_ready 1 once reset deasserts.
- Reset mid-operation aborts any pending or clear write immediately; nothing further is written.
- rx_ready = state in {IDLE, ESC_COLOR, ESC_POS}; decoded from the state register only, never from rx_valid.
- wr_en = (state==WRITE or state==CLEAR) & !hold; combinational from registered state and the hold input.
- IDLE, byte b accepted:
  - 0x20..0x7E: load wr_addr=cursor and wr_char=b. Load wr_color=rnd_color if cur_color==RND_CODE, else cur_color. Go to WRITE.
  - 0x0D (CR): cursor <= 0; stay in IDLE.
  - 0x08 (BS): cursor <= cursor-1, saturating at 0; stay in IDLE.
  - 0x1B (ESC): go to ESC_COLOR.
  - 0x10 (DLE): go to ESC_POS.
  - 0x0C (FF): clr_idx <= 0; go to CLEAR.
  - Any other byte is consumed and ignored.
- ESC_COLOR, byte b accepted: cur_color <= b[3:0]; go to IDLE. Any byte value is accepted as the argument.
- ESC_POS, byte b accepted: if b < NUM_CHARS, cursor <= b[ADDR_W-1:0]; otherwise cursor is unchanged. Go to IDLE either way.
- WRITE: on a commit edge (wr_en high), cursor <= cursor+1, wrapping from NUM_CHARS-1 to 0, and the state returns to IDLE. With hold low, a byte accepted at edge E commits at E+1, so sustained throughput is one printable byte per 2 cycles.
- CLEAR: outputs are wr_addr=clr_idx, wr_char=0x20, wr_color=0. Each commit increments clr_idx. The commit at clr_idx==NUM_CHARS-1 sets cursor <= 0 and returns to IDLE. cur_color is unchanged. With hold low, CLEAR lasts NUM_CHARS cycles.
- While hold is high: WRITE and CLEAR stall with wr_* stable and no commit. Accepting bytes in IDLE/ESC states continues, and cursor/color updates are not blocked.
- A hold rising edge never splits a commit, because wr_en is gated by hold in the same cycle.
- busy = state in {WRITE, CLEAR}.

Test Plan:
- Reset, hold=0, send "AB": wr_en pulses exactly twice. First pulse is addr 0 / char 0x41 / color 1, second is addr 1 / 0x42 / 1. Each pulse comes 1 cycle after accept; cursor ends at 2.
- Send 5 printable bytes with NUM_CHARS=4: addresses are 0,1,2,3,0 and the cursor ends at 1. Then send 0x08 twice: cursor goes 1 -> 0 -> 0 (saturates).
- Send ESC,0x23 then 'X': wr_color=3. Send ESC,0x0F with rnd_color=0xA at the accept edge of 'Y': wr_color=0xA. Send DLE,0x02 then 'Z': wr_addr=2. Send DLE,0x07 (out of range): cursor unchanged.
- Send 0x0C: exactly 4 consecutive wr_en cycles to addresses 0..3 with char 0x20 and color 0. rx_ready is low throughout and cursor=0 afterwards.
- Hold high for 10 cycles while 'Q' is accepted: wr_en stays 0, rx_ready stays 0, wr_* are stable. wr_en pulses in the first cycle after hold falls. Repeat with hold toggling during CLEAR: still exactly 4 commits, none while hold=1.
- Assert reset in the 2nd cycle of CLEAR: wr_en drops asynchronously and no further writes occur. After release: cursor 0, color 1, rx_ready 1.
